// File: rtl/fetch_sequencer_pkg.sv
// Shared Y86-64 encodings and fetch FSM state type used by the fetch stage and its decoder.
package fetch_sequencer_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] IDISP   = 4'hD;
    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_REGS,
        S_VALC,
        S_DONE
    } state_t;

endpackage

// File: rtl/fetch_sequencer_instr_length.sv
// Combinational icode decoder: which optional instruction fields follow byte 0.
module instr_length
    import fetch_sequencer_pkg::*;
(
    input  logic [3:0] icode,
    output logic       need_regids,
    output logic       need_valc,
    output logic       valid
);

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        valid       = 1'b1;
        unique case (icode)
            IHALT, INOP, IRET: ;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ, IDISP: need_regids = 1'b1;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            IJXX, ICALL: need_valc = 1'b1;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 fetch: reads one instruction through a req/valid byte port and splits its fields.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_valid,
    input  logic        imem_error,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_invalid,
    output logic        mem_fault
);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  off_q, off_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d;
    logic [63:0] valc_q, valc_d, valp_q, valp_d;
    logic        invalid_q, invalid_d, fault_q, fault_d;

    logic [63:0] byte_addr;
    logic [3:0]  dec_icode;
    logic        dec_regids, dec_valc, dec_valid;
    logic        fetching;

    // In BYTE0 the decoder looks at the incoming byte; afterwards at the latched icode.
    assign dec_icode = (state_q == S_BYTE0) ? imem_rdata[7:4] : icode_q;

    instr_length u_len (
        .icode       (dec_icode),
        .need_regids (dec_regids),
        .need_valc   (dec_valc),
        .valid       (dec_valid)
    );

    assign byte_addr = pc_q + {60'd0, off_q};
    assign fetching  = (state_q == S_BYTE0) || (state_q == S_REGS) || (state_q == S_VALC);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        off_d     = off_q;
        k_d       = k_q;
        icode_d   = icode_q;
        ifun_d    = ifun_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        valc_d    = valc_q;
        valp_d    = valp_q;
        invalid_d = invalid_q;
        fault_d   = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = pc;
                    off_d     = 4'd0;
                    k_d       = 3'd0;
                    ra_d      = RNONE;
                    rb_d      = RNONE;
                    valc_d    = 64'd0;
                    invalid_d = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = S_BYTE0;
                end
            end
            S_BYTE0, S_REGS, S_VALC: begin
                if (imem_valid && imem_error) begin
                    // Faulting byte is dropped, so valP covers only bytes already accepted.
                    fault_d = 1'b1;
                    valp_d  = byte_addr;
                    state_d = S_DONE;
                end else if (imem_valid) begin
                    off_d  = off_q + 4'd1;
                    valp_d = byte_addr + 64'd1;
                    if (state_q == S_BYTE0) begin
                        icode_d = imem_rdata[7:4];
                        ifun_d  = imem_rdata[3:0];
                        if (!dec_valid) begin
                            invalid_d = 1'b1;
                            state_d   = S_DONE;
                        end else if (dec_regids) begin
                            state_d = S_REGS;
                        end else if (dec_valc) begin
                            state_d = S_VALC;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (state_q == S_REGS) begin
                        ra_d    = imem_rdata[7:4];
                        rb_d    = imem_rdata[3:0];
                        state_d = dec_valc ? S_VALC : S_DONE;
                    end else begin
                        valc_d[{k_q, 3'b000} +: 8] = imem_rdata;
                        k_d = k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= 64'd0;
            off_q     <= 4'd0;
            k_q       <= 3'd0;
            icode_q   <= INOP;
            ifun_q    <= 4'd0;
            ra_q      <= RNONE;
            rb_q      <= RNONE;
            valc_q    <= 64'd0;
            valp_q    <= 64'd0;
            invalid_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            off_q     <= off_d;
            k_q       <= k_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            valc_q    <= valc_d;
            valp_q    <= valp_d;
            invalid_q <= invalid_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req      = fetching;
    assign imem_addr     = byte_addr;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign icode         = icode_q;
    assign ifun          = ifun_q;
    assign rA            = ra_q;
    assign rB            = rb_q;
    assign valC          = valc_q;
    assign valP          = valp_q;
    assign instr_invalid = invalid_q;
    assign mem_fault     = fault_q;

endmodule
